// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: operand/op bundle from decode and write-port bundle to the register bank
interface alu_exec_stage_if;
  logic       i_Valid;
  logic [3:0] i_Op;
  logic [7:0] i_Data1;
  logic [7:0] i_Data2;
  logic [2:0] i_AddrRegDest;
  logic       i_WriteEn;
  logic       o_Stall;
  logic       o_WriteBack;
  logic [2:0] o_AddrRegDest;
  logic [7:0] o_WriteData;
  logic       o_Zero;
  logic       o_Carry;
  logic       o_Neg;
  modport master (
    output i_Valid, i_Op, i_Data1, i_Data2, i_AddrRegDest, i_WriteEn,
    input  o_Stall, o_WriteBack, o_AddrRegDest, o_WriteData, o_Zero, o_Carry, o_Neg
  );
  modport slave (
    input  i_Valid, i_Op, i_Data1, i_Data2, i_AddrRegDest, i_WriteEn,
    output o_Stall, o_WriteBack, o_AddrRegDest, o_WriteData, o_Zero, o_Carry, o_Neg
  );
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: pipelined 8-bit ALU with iterative shift-add MUL driving a delayed-data bank write port
module alu_exec_stage #(
  parameter int DATA_W = 8,
  parameter bit MUL_EN = 1'b1
) (
  input logic i_CLK,
  input logic i_RST,
  alu_exec_stage_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic {IDLE, MUL_RUN} state_t;
  state_t state_q, state_d;
  logic [2*DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_nx;
  logic [DATA_W-1:0] mplier_q, mplier_d, wdata_q, wdata_d, pdata_q, pdata_d, res;
  logic [DATA_W:0] sum, dif;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] dest_q, dest_d, addr_q, addr_d;
  logic we_q, we_d, wb_q, wb_d, pend_q, pend_d;
  logic z_q, z_d, c_q, c_d, n_q, n_d;
  logic cy, accept, is_mul, done;
  always_comb begin
    sum = {1'b0, bus.i_Data1} + {1'b0, bus.i_Data2};
    dif = {1'b0, bus.i_Data1} - {1'b0, bus.i_Data2};
    res = bus.i_Data1;
    cy  = 1'b0;
    case (bus.i_Op)
      4'd1:       {cy, res} = sum;
      4'd2, 4'd9: {cy, res} = dif;
      4'd3:       res = bus.i_Data1 & bus.i_Data2;
      4'd4:       res = bus.i_Data1 | bus.i_Data2;
      4'd5:       res = bus.i_Data1 ^ bus.i_Data2;
      4'd6:       res = ~bus.i_Data1;
      4'd7:       {cy, res} = {bus.i_Data1, 1'b0};
      4'd8:       {res, cy} = {1'b0, bus.i_Data1};
      default:    ;
    endcase
  end
  // MUL_RUN takes priority: i_Valid during a stall is dropped, not queued
  always_comb begin
    accept   = bus.i_Valid && state_q == IDLE;
    is_mul   = MUL_EN && bus.i_Op == 4'd10;
    done     = state_q == MUL_RUN && cnt_q == CW'(DATA_W - 1);
    acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    we_d     = we_q;
    addr_d   = addr_q;
    z_d      = z_q;
    c_d      = c_q;
    n_d      = n_q;
    wb_d     = 1'b0;
    pend_d   = 1'b0;
    pdata_d  = pdata_q;
    wdata_d  = pend_q ? pdata_q : wdata_q;
    if (state_q == MUL_RUN) begin
      acc_d    = acc_nx;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done) begin
        state_d = IDLE;
        wb_d    = we_q;
        pend_d  = we_q;
        pdata_d = acc_nx[DATA_W-1:0];
        addr_d  = dest_q;
        z_d     = acc_nx[DATA_W-1:0] == '0;
        c_d     = |acc_nx[2*DATA_W-1:DATA_W];
        n_d     = acc_nx[DATA_W-1];
      end
    end else if (accept && is_mul) begin
      state_d  = MUL_RUN;
      acc_d    = '0;
      mcand_d  = {{DATA_W{1'b0}}, bus.i_Data1};
      mplier_d = bus.i_Data2;
      cnt_d    = '0;
      dest_d   = bus.i_AddrRegDest;
      we_d     = bus.i_WriteEn;
    end else if (accept && bus.i_Op <= 4'd9) begin
      wb_d    = bus.i_WriteEn && bus.i_Op != 4'd9;
      pend_d  = wb_d;
      pdata_d = res;
      addr_d  = bus.i_AddrRegDest;
      z_d     = res == '0;
      c_d     = cy;
      n_d     = res[DATA_W-1];
    end
  end
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      dest_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      wb_q     <= 1'b0;
      pend_q   <= 1'b0;
      pdata_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      dest_q   <= dest_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      z_q      <= z_d;
      c_q      <= c_d;
      n_q      <= n_d;
      wb_q     <= wb_d;
      pend_q   <= pend_d;
      pdata_q  <= pdata_d;
      wdata_q  <= wdata_d;
    end
  end
  assign bus.o_Stall       = state_q == MUL_RUN;
  assign bus.o_WriteBack   = wb_q;
  assign bus.o_AddrRegDest = addr_q;
  assign bus.o_WriteData   = wdata_q;
  assign bus.o_Zero        = z_q;
  assign bus.o_Carry       = c_q;
  assign bus.o_Neg         = n_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: scoreboard bench with directed and random ops against an arithmetic reference model
module tb_alu_exec_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  alu_exec_stage_if bus();
  alu_exec_stage #(.DATA_W(8), .MUL_EN(1'b1)) dut (.i_CLK(clk), .i_RST(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {int dest; int res; int z; int c; int n;} exp_t;
  exp_t sb[$];
  int npass = 0;
  int ntot = 0;
  int mz = 0, mc = 0, mn = 0;
  task automatic chk(string nm, int act, int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  function automatic int ref_res(int op, int a, int b, output int c);
    int r;
    c = 0;
    r = a;
    case (op)
      1: begin r = (a + b) % 256; c = (a + b) > 255; end
      2, 9: begin r = (a - b + 256) % 256; c = a < b; end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = 255 - a;
      7: begin r = (a * 2) % 256; c = a >= 128; end
      8: begin r = a / 2; c = a % 2; end
      10: begin r = (a * b) % 256; c = (a * b) > 255; end
      default: ;
    endcase
    return r;
  endfunction
  task automatic issue(int op, int a, int b, int dest, int we, bit push = 1'b1);
    int n = 0;
    int c, r;
    while (bus.o_Stall && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 40) chk("stall_timeout", 1, 0);
    bus.i_Valid = 1'b1;
    bus.i_Op = op[3:0];
    bus.i_Data1 = a[7:0];
    bus.i_Data2 = b[7:0];
    bus.i_AddrRegDest = dest[2:0];
    bus.i_WriteEn = we[0];
    if (push && op <= 10) begin
      r = ref_res(op, a, b, c);
      mz = (r == 0); mc = c; mn = (r >= 128);
      if (we != 0 && op != 9) sb.push_back('{dest, r, mz, mc, mn});
    end
    @(posedge clk); #1;
    bus.i_Valid = 1'b0;
  endtask
  initial begin : monitor
    int due = 0;
    int dexp = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (due != 0) begin
        chk("wdata", int'(bus.o_WriteData), dexp);
        due = 0;
      end
      if (bus.o_WriteBack) begin
        if (sb.size() == 0) chk("unexpected_wb", 1, 0);
        else begin
          e = sb.pop_front();
          chk("wb_addr", int'(bus.o_AddrRegDest), e.dest);
          chk("wb_zero", int'(bus.o_Zero), e.z);
          chk("wb_carry", int'(bus.o_Carry), e.c);
          chk("wb_neg", int'(bus.o_Neg), e.n);
          due = 1;
          dexp = e.res;
        end
      end
    end
  end
  task automatic chk_zero_outputs(string tag);
    chk({tag, "_stall"}, int'(bus.o_Stall), 0);
    chk({tag, "_wb"}, int'(bus.o_WriteBack), 0);
    chk({tag, "_addr"}, int'(bus.o_AddrRegDest), 0);
    chk({tag, "_wdata"}, int'(bus.o_WriteData), 0);
    chk({tag, "_flags"}, int'({bus.o_Zero, bus.o_Carry, bus.o_Neg}), 0);
  endtask
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin : stim
    int sc;
    bus.i_Valid = 1'b0; bus.i_Op = '0; bus.i_Data1 = '0; bus.i_Data2 = '0;
    bus.i_AddrRegDest = '0; bus.i_WriteEn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    issue(1, 'hF0, 'h20, 3, 1);
    @(negedge clk);
    chk("add_wb", int'(bus.o_WriteBack), 1);
    chk("add_carry", int'(bus.o_Carry), 1);
    @(negedge clk);
    chk("add_wb_pulse", int'(bus.o_WriteBack), 0);
    issue(2, 'h05, 'h05, 1, 1);
    issue(5, 'hAA, 'h0F, 2, 1);
    repeat (3) @(posedge clk); #1;
    issue(10, 'h13, 'h0E, 5, 1);
    sc = 0;
    while (bus.o_Stall && sc < 20) begin
      bus.i_Valid = (sc == 2 || sc == 5);
      bus.i_Op = 4'd1; bus.i_WriteEn = 1'b1; bus.i_AddrRegDest = 3'd6;
      @(posedge clk); #1; sc++;
    end
    bus.i_Valid = 1'b0;
    chk("mul_stall_cycles", sc, 8);
    chk("mul_wb", int'(bus.o_WriteBack), 1);
    chk("mul_carry", int'(bus.o_Carry), 1);
    repeat (3) @(posedge clk); #1;
    issue(9, 'h03, 'h07, 0, 1);
    @(negedge clk);
    chk("cmp_no_wb", int'(bus.o_WriteBack), 0);
    chk("cmp_flags", int'({bus.o_Zero, bus.o_Carry, bus.o_Neg}), {mz, mc, mn} == 3 ? 0 : int'({mz[0], mc[0], mn[0]}));
    chk("cmp_carry_neg", int'({bus.o_Carry, bus.o_Neg}), 3);
    issue(12, 'h00, 'h00, 4, 1);
    @(negedge clk);
    chk("nop_no_wb", int'(bus.o_WriteBack), 0);
    chk("nop_flags_held", int'({bus.o_Zero, bus.o_Carry, bus.o_Neg}), 3);
    repeat (2) @(posedge clk); #1;
    issue(10, 'hFF, 'hFF, 4, 1, 1'b0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mz = 0; mc = 0; mn = 0;
    chk_zero_outputs("mul_abort");
    repeat (12) @(posedge clk); #1;
    chk("abort_still_idle", int'(bus.o_Stall), 0);
    issue(0, 'h55, 'h00, 7, 1);
    issue(7, 'h81, 'h00, 1, 1);
    issue(8, 'h01, 'h00, 2, 1);
    @(negedge clk);
    chk("shr_flags", int'({bus.o_Zero, bus.o_Carry}), 3);
    repeat (3) @(posedge clk); #1;
    repeat (60) begin
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    repeat (15) @(posedge clk); #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
